// File: rtl/bp_cfg_loader_pkg.sv
// rtl/bp_cfg_loader_pkg.sv - shared widths, cfg write packet and loader state for bp_cfg_loader
package bp_cfg_loader_pkg;

  typedef struct packed {
    int unsigned cfg_core_width;
    int unsigned cfg_addr_width;
    int unsigned cfg_data_width;
  } bp_proc_param_s;

  localparam bp_proc_param_s BP_PROC_PARAM = '{
    cfg_core_width: 8,
    cfg_addr_width: 16,
    cfg_data_width: 32
  };

  localparam int unsigned CFG_CORE_WIDTH = BP_PROC_PARAM.cfg_core_width;
  localparam int unsigned CFG_ADDR_WIDTH = BP_PROC_PARAM.cfg_addr_width;
  localparam int unsigned CFG_DATA_WIDTH = BP_PROC_PARAM.cfg_data_width;

  // One config write as seen on the link: destination core, address, data.
  typedef struct packed {
    logic [CFG_CORE_WIDTH-1:0] core;
    logic [CFG_ADDR_WIDTH-1:0] addr;
    logic [CFG_DATA_WIDTH-1:0] data;
  } bp_cfg_pkt_s;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } loader_state_e;

  // Index width that never collapses to zero bits for a single-entry table.
  function automatic int unsigned safe_clog2(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bp_cfg_loader_if.sv
// rtl/bp_cfg_loader_if.sv - valid/ready config write link between loader and receivers
interface bp_cfg_loader_if #(
  parameter int core_width_p = 8,
  parameter int addr_width_p = 16,
  parameter int data_width_p = 32
);
  logic                    cfg_v;
  logic                    cfg_ready;
  logic [core_width_p-1:0] cfg_core;
  logic [addr_width_p-1:0] cfg_addr;
  logic [data_width_p-1:0] cfg_data;

  modport master (
    output cfg_v, cfg_core, cfg_addr, cfg_data,
    input  cfg_ready
  );

  modport slave (
    input  cfg_v, cfg_core, cfg_addr, cfg_data,
    output cfg_ready
  );
endinterface

// File: rtl/bp_cfg_loader_next_entry.sv
// rtl/bp_cfg_loader_next_entry.sv - first enabled entry above an index (or from the start)
module bp_cfg_loader_next_entry #(
  parameter int num_entries_p = 8,
  parameter int idx_width_p   = 3
) (
  input  logic [num_entries_p-1:0] en_i,
  input  logic [idx_width_p-1:0]   cur_i,
  input  logic                     from_start_i,
  output logic                     found_o,
  output logic [idx_width_p-1:0]   idx_o
);

  // Scan high to low so the last hit written is the lowest qualifying index.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int k = num_entries_p - 1; k >= 0; k--) begin
      if (en_i[k] && (from_start_i || (k > int'(cur_i)))) begin
        found_o = 1'b1;
        idx_o   = idx_width_p'(k);
      end
    end
  end

endmodule

// File: rtl/bp_cfg_loader.sv
// rtl/bp_cfg_loader.sv - walks cores x enabled table entries onto the config link, then flags done
module bp_cfg_loader
  import bp_cfg_loader_pkg::*;
#(
  parameter int num_core_p       = 1,
  parameter int num_entries_p    = 8,
  parameter int cfg_core_width_p = CFG_CORE_WIDTH,
  parameter int cfg_addr_width_p = CFG_ADDR_WIDTH,
  parameter int cfg_data_width_p = CFG_DATA_WIDTH
) (
  input  logic                                                    clk_i,
  input  logic                                                    reset_i,
  input  logic                                                    start_i,
  input  logic [num_entries_p-1:0]                                entry_en_i,
  input  logic [num_entries_p*(cfg_addr_width_p+cfg_data_width_p)-1:0] cfg_table_i,
  bp_cfg_loader_if.master                                         cfg_if,
  output logic                                                    busy_o,
  output logic                                                    done_o
);

  localparam int ENTRY_W  = cfg_addr_width_p + cfg_data_width_p;
  localparam int CORE_CW  = $clog2(num_core_p + 1);
  localparam int ENTRY_CW = safe_clog2(num_entries_p);
  localparam logic [CORE_CW-1:0] LAST_CORE = CORE_CW'(num_core_p - 1);

  loader_state_e                state_q, state_d;
  logic [CORE_CW-1:0]           core_q, core_d;
  logic [ENTRY_CW-1:0]          entry_q, entry_d;
  logic                         v_q, v_d;
  logic                         busy_q, busy_d;
  logic                         done_q, done_d;
  logic [cfg_addr_width_p-1:0]  addr_q, addr_d;
  logic [cfg_data_width_p-1:0]  data_q, data_d;

  logic [ENTRY_W-1:0]           tbl [num_entries_p];
  logic                         first_found, next_found;
  logic [ENTRY_CW-1:0]          first_idx, next_idx;

  for (genvar g = 0; g < num_entries_p; g++) begin : g_unpack
    assign tbl[g] = cfg_table_i[g*ENTRY_W +: ENTRY_W];
  end

  bp_cfg_loader_next_entry #(
    .num_entries_p (num_entries_p),
    .idx_width_p   (ENTRY_CW)
  ) u_first (
    .en_i         (entry_en_i),
    .cur_i        ('0),
    .from_start_i (1'b1),
    .found_o      (first_found),
    .idx_o        (first_idx)
  );

  bp_cfg_loader_next_entry #(
    .num_entries_p (num_entries_p),
    .idx_width_p   (ENTRY_CW)
  ) u_next (
    .en_i         (entry_en_i),
    .cur_i        (entry_q),
    .from_start_i (1'b0),
    .found_o      (next_found),
    .idx_o        (next_idx)
  );

  // Next-state and next-output computation; outputs are registered so they hold while stalled.
  always_comb begin
    state_d = state_q;
    core_d  = core_q;
    entry_d = entry_q;
    v_d     = v_q;
    busy_d  = busy_q;
    done_d  = done_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          done_d = 1'b0;
          if (first_found) begin
            state_d          = ST_SEND;
            core_d           = '0;
            entry_d          = first_idx;
            v_d              = 1'b1;
            busy_d           = 1'b1;
            {addr_d, data_d} = tbl[first_idx];
          end else begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
      end
      ST_SEND: begin
        // start_i is deliberately not looked at here.
        if (cfg_if.cfg_ready) begin
          if (next_found) begin
            entry_d          = next_idx;
            {addr_d, data_d} = tbl[next_idx];
          end else if (core_q == LAST_CORE) begin
            state_d = ST_DONE;
            v_d     = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            core_d  = '0;
            entry_d = '0;
            addr_d  = '0;
            data_d  = '0;
          end else begin
            core_d           = core_q + CORE_CW'(1);
            entry_d          = first_idx;
            {addr_d, data_d} = tbl[first_idx];
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        v_d     = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  // State, counters and output registers; reset drops every output immediately.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      core_q  <= '0;
      entry_q <= '0;
      v_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      core_q  <= core_d;
      entry_q <= entry_d;
      v_q     <= v_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign cfg_if.cfg_v    = v_q;
  assign cfg_if.cfg_core = cfg_core_width_p'(core_q);
  assign cfg_if.cfg_addr = addr_q;
  assign cfg_if.cfg_data = data_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;

endmodule

// File: tb/tb_bp_cfg_loader.sv
// tb/tb_bp_cfg_loader.sv - self-checking bench for bp_cfg_loader
module tb_bp_cfg_loader;
  import bp_cfg_loader_pkg::*;

  localparam int NE = 8;
  localparam int EW = 48;

  logic clk;
  logic rst;

  logic            start_a;
  logic [NE-1:0]   en_a;
  logic [NE*EW-1:0] tbl_a;
  logic            busy_a, done_a;

  logic            start_b;
  logic [0:0]      en_b;
  logic [EW-1:0]   tbl_b;
  logic            busy_b, done_b;

  bp_cfg_loader_if #(.core_width_p(8), .addr_width_p(16), .data_width_p(32)) cfg_a ();
  bp_cfg_loader_if #(.core_width_p(8), .addr_width_p(16), .data_width_p(32)) cfg_b ();

  bp_cfg_loader #(
    .num_core_p(2), .num_entries_p(NE),
    .cfg_core_width_p(8), .cfg_addr_width_p(16), .cfg_data_width_p(32)
  ) dut_a (
    .clk_i(clk), .reset_i(rst), .start_i(start_a), .entry_en_i(en_a),
    .cfg_table_i(tbl_a), .cfg_if(cfg_a), .busy_o(busy_a), .done_o(done_a)
  );

  bp_cfg_loader #(
    .num_core_p(1), .num_entries_p(1),
    .cfg_core_width_p(8), .cfg_addr_width_p(16), .cfg_data_width_p(32)
  ) dut_b (
    .clk_i(clk), .reset_i(rst), .start_i(start_b), .entry_en_i(en_b),
    .cfg_table_i(tbl_b), .cfg_if(cfg_b), .busy_o(busy_b), .done_o(done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  bp_cfg_pkt_s exp_q[$];
  bit mon_en = 0;
  bit prev_stall = 0;
  bit chk_done_next = 0;
  int v_cycles = 0;
  int hs_count = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [15:0] addr_of(input int e);
    return 16'h0100 + 16'(e);
  endfunction

  function automatic logic [31:0] data_of(input int e);
    return 32'hA5A5_0000 | (32'(e) * 32'h111);
  endfunction

  // Expected writes: every core in order, each enabled entry in ascending index.
  task automatic build_model();
    bp_cfg_pkt_s p;
    exp_q.delete();
    for (int c = 0; c < 2; c++)
      for (int e = 0; e < NE; e++)
        if (en_a[e]) begin
          p.core = 8'(c);
          p.addr = tbl_a[e*EW + 32 +: 16];
          p.data = tbl_a[e*EW +: 32];
          exp_q.push_back(p);
        end
  endtask

  // Compare process: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall    = 0;
      chk_done_next = 0;
    end else begin
      if (chk_done_next) begin
        chk("done_after_last", {62'd0, done_a, cfg_a.cfg_v}, 64'h2);
        chk_done_next = 0;
      end
      if (mon_en) begin
        chk("busy_eq_v", {63'd0, busy_a}, {63'd0, cfg_a.cfg_v});
        if (prev_stall) chk("v_held_stall", {63'd0, cfg_a.cfg_v}, 64'd1);
        if (cfg_a.cfg_v) begin
          v_cycles++;
          if (exp_q.size() == 0) begin
            chk("extra_write", 64'd1, 64'd0);
          end else begin
            chk("write_fields", {8'd0, cfg_a.cfg_core, cfg_a.cfg_addr, cfg_a.cfg_data},
                {8'd0, exp_q[0].core, exp_q[0].addr, exp_q[0].data});
            if (cfg_a.cfg_ready) begin
              void'(exp_q.pop_front());
              hs_count++;
              if (exp_q.size() == 0) chk_done_next = 1;
            end
          end
        end
        prev_stall = cfg_a.cfg_v && !cfg_a.cfg_ready;
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
  endtask

  task automatic wait_done(input bit bp, input int pulse_at);
    for (int i = 0; i < 200; i++) begin
      if (done_a) break;
      @(posedge clk); #1;
      start_a = (i == pulse_at);
      if (bp) cfg_a.cfg_ready = 1'($urandom_range(0, 1));
    end
    start_a = 1'b0;
    cfg_a.cfg_ready = 1'b1;
    chk("done_reached", {63'd0, done_a}, 64'd1);
    chk("model_drained", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    en_a = '0;
    en_b = 1'b1;
    tbl_b = {16'h0004, 32'h0000_0001};
    cfg_a.cfg_ready = 1'b0;
    cfg_b.cfg_ready = 1'b1;
    for (int e = 0; e < NE; e++) tbl_a[e*EW +: EW] = {addr_of(e), data_of(e)};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_v",    {63'd0, cfg_a.cfg_v}, 64'd0);
    chk("rst_busy", {63'd0, busy_a}, 64'd0);
    chk("rst_done", {63'd0, done_a}, 64'd0);
    chk("rst_fields", {8'd0, cfg_a.cfg_core, cfg_a.cfg_addr, cfg_a.cfg_data}, 64'd0);
    rst = 1'b0;

    // Two cores, entries 0,2,5, receiver always ready.
    en_a = 8'b0010_0101;
    build_model();
    chk("model_len", 64'(exp_q.size()), 64'd6);
    chk("model_first", {8'd0, exp_q[0].core, exp_q[0].addr, exp_q[0].data}, 64'h00_00_0100_A5A50000);
    chk("model_second", {8'd0, exp_q[1].core, exp_q[1].addr, exp_q[1].data}, 64'h00_00_0102_A5A50222);
    chk("model_last", {8'd0, exp_q[5].core, exp_q[5].addr, exp_q[5].data}, 64'h00_01_0105_A5A50555);
    mon_en = 1;
    cfg_a.cfg_ready = 1'b1;
    v_cycles = 0;
    pulse_start();
    chk("start_latency", {63'd0, cfg_a.cfg_v}, 64'd1);
    wait_done(0, -1);
    chk("consecutive_writes", 64'(v_cycles), 64'd6);

    // Random backpressure.
    build_model();
    cfg_a.cfg_ready = 1'b0;
    pulse_start();
    wait_done(1, -1);

    // No entries enabled.
    en_a = '0;
    build_model();
    v_cycles = 0;
    pulse_start();
    chk("zero_en_done", {62'd0, done_a, cfg_a.cfg_v}, 64'h2);
    repeat (3) @(posedge clk);
    #1;
    chk("zero_en_no_v", 64'(v_cycles), 64'd0);

    // Reset after the third handshake, then a full rerun.
    en_a = 8'b0010_0101;
    build_model();
    hs_count = 0;
    pulse_start();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (hs_count >= 3) break;
    end
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_v",    {63'd0, cfg_a.cfg_v}, 64'd0);
    chk("midrst_busy", {63'd0, busy_a}, 64'd0);
    chk("midrst_fields", {8'd0, cfg_a.cfg_core, cfg_a.cfg_addr, cfg_a.cfg_data}, 64'd0);
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    build_model();
    pulse_start();
    chk("after_rst_first", {8'd0, cfg_a.cfg_core, cfg_a.cfg_addr, cfg_a.cfg_data}, 64'h00_00_0100_A5A50000);
    wait_done(0, -1);

    // start_i during SEND is ignored; start_i in DONE reruns.
    build_model();
    pulse_start();
    wait_done(0, 2);
    build_model();
    pulse_start();
    chk("rerun_done_clear", {62'd0, done_a, cfg_a.cfg_v}, 64'h1);
    wait_done(1, 1);

    // Single core, single entry.
    @(posedge clk); #1 start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    chk("b_write", {7'd0, cfg_b.cfg_v, cfg_b.cfg_core, cfg_b.cfg_addr, cfg_b.cfg_data},
        64'h01_00_0004_00000001);
    chk("b_busy", {63'd0, busy_b}, 64'd1);
    @(posedge clk); #1;
    chk("b_done", {62'd0, done_b, cfg_b.cfg_v}, 64'h2);

    mon_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
